// File: rtl/stim_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stim_sweep_pkg
//  Description : Shared types, constants and helpers for the stimulus sweep
//                generator (state encoding, vector width, LFSR taps and
//                sweep lengths).
//  Revision    : 1.0  initial release
// ============================================================================
package stim_sweep_pkg;

    localparam int VEC_W = 8;

    // Taps for x^8+x^6+x^5+x^4+1, applied to a left-shifting register whose
    // feedback enters bit 0.
    localparam logic [VEC_W-1:0] LFSR_TAPS = 8'b1011_1000;

    localparam int EXH_LEN  = 256;
    localparam int LFSR_LEN = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    // One LFSR step: shift left, feed the tap parity into bit 0.
    function automatic logic [VEC_W-1:0] lfsr_step(input logic [VEC_W-1:0] v);
        return {v[VEC_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    // The all-zero state locks the LFSR, so a zero seed is promoted to 1.
    function automatic logic [VEC_W-1:0] seed_fix(input logic [VEC_W-1:0] s);
        return (s == '0) ? {{(VEC_W-1){1'b0}}, 1'b1} : s;
    endfunction

endpackage : stim_sweep_pkg
`default_nettype wire

// File: rtl/stim_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module      : stim_lfsr8
//  Description : 8-bit maximal-length Fibonacci LFSR with synchronous load
//                and step enable. A load stores the step *after* the
//                (zero-protected) seed, so state_o always holds the vector
//                that follows the one currently being driven.
//  Revision    : 1.0  initial release
// ============================================================================
module stim_lfsr8
    import stim_sweep_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [VEC_W-1:0] seed_i,
    output logic [VEC_W-1:0] state_o
);

    logic [VEC_W-1:0] r_state;

    // Load runs one step ahead of the seed; enable advances one step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= {{(VEC_W-1){1'b0}}, 1'b1};
        end else if (load_i) begin
            r_state <= lfsr_step(seed_fix(seed_i));
        end else if (en_i) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign state_o = r_state;

endmodule : stim_lfsr8
`default_nettype wire

// File: rtl/stim_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module      : stim_sweep_gen
//  Description : Drives an 8-input DUT with an exhaustive or LFSR vector
//                sweep, aligns each issued vector with the DUT's fixed
//                latency, and counts o1/o2 disagreements, remembering the
//                first failing vector.
//  Revision    : 1.0  initial release
// ============================================================================
module stim_sweep_gen
    import stim_sweep_pkg::*;
#(
    parameter int LAT = 1
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic [7:0] seed_i,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h,
    input  logic       o1_i,
    input  logic       o2_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [8:0] mis_cnt_o,
    output logic [7:0] first_bad_o,
    output logic       first_bad_vld_o
);

    // Last DRAIN count value; only meaningful when LAT > 0.
    localparam logic [3:0] c_DRAIN_LAST = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
    localparam logic [8:0] c_EXH_LEN    = 9'(EXH_LEN);
    localparam logic [8:0] c_LFSR_LEN   = 9'(LFSR_LEN);

    sweep_state_t     r_state;
    sweep_state_t     w_state_nxt;

    logic             r_mode;
    logic [VEC_W-1:0] r_vec;
    logic [8:0]       r_issued;
    logic [3:0]       r_drain;

    logic [8:0]       r_mis;
    logic [VEC_W-1:0] r_fb;
    logic             r_fb_vld;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic [VEC_W-1:0] w_lfsr_state;

    logic             w_in_vld;
    logic             w_tap_vld;
    logic [VEC_W-1:0] w_tap_vec;

    // The vector on a..h is the last of the sweep once the issue count
    // reaches the mode's sweep length.
    assign w_last = (r_issued == (r_mode ? c_LFSR_LEN : c_EXH_LEN));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the per-state strobes and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = (LAT == 0) ? DONE : DRAIN;
                end else begin
                    w_step = 1'b1;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (r_drain == c_DRAIN_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    stim_lfsr8 u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_accept),
        .en_i    (w_step & r_mode),
        .seed_i  (seed_i),
        .state_o (w_lfsr_state)
    );

    // Vector generator: load on start, advance while RUN continues, and
    // force the DUT inputs to zero everywhere else.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode   <= 1'b0;
            r_vec    <= '0;
            r_issued <= '0;
        end else if (w_accept) begin
            r_mode   <= mode_i;
            r_vec    <= mode_i ? seed_fix(seed_i) : '0;
            r_issued <= 9'd1;
        end else if (w_step) begin
            r_vec    <= r_mode ? w_lfsr_state : (r_vec + 8'd1);
            r_issued <= r_issued + 9'd1;
        end else begin
            r_vec    <= '0;
        end
    end

    // Counts DRAIN cycles so exactly LAT of them elapse before DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drain <= '0;
        end else if (r_state == DRAIN) begin
            r_drain <= r_drain + 4'd1;
        end else begin
            r_drain <= '0;
        end
    end

    // A vector is "in flight" only while it is a genuine RUN vector.
    assign w_in_vld = (r_state == RUN);

    generate
        if (LAT == 0) begin : g_lat0
            // Combinational DUT: its outputs correspond to the current a..h.
            assign w_tap_vld = w_in_vld;
            assign w_tap_vec = r_vec;
        end else begin : g_pipe
            logic [LAT-1:0]   r_vld;
            logic [VEC_W-1:0] r_vecs [LAT];

            // Valid bits are reset so an aborted sweep leaves nothing to compare.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_in_vld;
                    for (int i = 1; i < LAT; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            // Vector payload follows the valid bits; no reset needed.
            always_ff @(posedge clk_i) begin
                r_vecs[0] <= r_vec;
                for (int i = 1; i < LAT; i++) begin
                    r_vecs[i] <= r_vecs[i-1];
                end
            end

            assign w_tap_vld = r_vld[LAT-1];
            assign w_tap_vec = r_vecs[LAT-1];
        end
    endgenerate

    // Mismatch counter and first-failure capture; cleared by an accepted start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mis    <= '0;
            r_fb     <= '0;
            r_fb_vld <= 1'b0;
        end else if (w_accept) begin
            r_mis    <= '0;
            r_fb     <= '0;
            r_fb_vld <= 1'b0;
        end else if (w_tap_vld && (o1_i != o2_i)) begin
            r_mis <= r_mis + 9'd1;
            if (!r_fb_vld) begin
                r_fb     <= w_tap_vec;
                r_fb_vld <= 1'b1;
            end
        end
    end

    assign {a, b, c, d, e, f, g, h} = r_vec;

    assign busy_o          = w_busy;
    assign done_o          = w_done;
    assign mis_cnt_o       = r_mis;
    assign first_bad_o     = r_fb;
    assign first_bad_vld_o = r_fb_vld;

endmodule : stim_sweep_gen
`default_nettype wire
